// File: rtl/seletor_sequencial.sv
// seletor_sequencial: sign-magnitude calculator (mult / soma / subt) controlled by push buttons.
// Define SELETOR_DEBOUNCE_EN to add a per-button debounce filter of DEBOUNCE_CYCLES samples.
//
// state | meaning
// OFF   | calculator off, outputs cleared
// IDLE  | on, waiting for an operation press
// CALC  | operation running (1 cycle soma/subt, WIDTH cycles mult)
// DONE  | result registered, valid pulse, back to IDLE
module seletor_sequencial #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sinal_a,
  input  logic               sinal_b,
  input  logic               botao_1,
  input  logic               botao_2,
  input  logic               botao_3,
  input  logic               botao_4,
  output logic [2*WIDTH-1:0] saida,
  output logic               sinal_saida,
  output logic [2:0]         sel,
  output logic               ligado,
  output logic               busy,
  output logic               valid
);
  localparam int RW = 2 * WIDTH;

  if (WIDTH < 2 || WIDTH > 16 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_param_check
    $error("seletor_sequencial: parameter out of range");
  end

  typedef enum logic [1:0] {S_OFF, S_IDLE, S_CALC, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [3:0] w_btn, w_cond, w_edge;
  logic [3:0] r_sync1, r_sync2, r_cond_d, r_armed;
  logic [1:0] r_fill;

  assign w_btn = {botao_4, botao_3, botao_2, botao_1};

  // r_armed blocks edges until a real low level has been sampled after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_fill   <= '0;
      r_armed  <= '0;
      r_cond_d <= '0;
    end else begin
      r_sync1  <= w_btn;
      r_sync2  <= r_sync1;
      r_fill   <= {r_fill[0], 1'b1};
      if (r_fill[1]) r_armed <= r_armed | ~r_sync2;
      r_cond_d <= w_cond;
    end
  end

`ifdef SELETOR_DEBOUNCE_EN
  localparam logic [7:0] DB_LOAD = 8'(DEBOUNCE_CYCLES - 1);
  logic [3:0][7:0] r_db_cnt;
  logic [3:0]      r_db_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= {4{DB_LOAD}};
      r_db_lvl <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_db_lvl[i]) begin
          r_db_cnt[i] <= DB_LOAD;
        end else if (r_db_cnt[i] == 8'd0) begin
          r_db_lvl[i] <= r_sync2[i];
          r_db_cnt[i] <= DB_LOAD;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] - 8'd1;
        end
      end
    end
  end
  assign w_cond = r_db_lvl;
`else
  assign w_cond = r_sync2;
`endif

  assign w_edge = w_cond & ~r_cond_d & r_armed;

  logic [WIDTH-1:0] r_a, r_b, r_mplier;
  logic             r_sa, r_sb, r_sinal;
  logic [RW-1:0]    r_acc, r_mcand, r_saida;
  logic [2:0]       r_sel, w_op_sel;
  logic [4:0]       r_cnt;
  logic             w_abort, w_accept;

  assign w_abort  = (r_state != S_OFF) && w_edge[3];
  assign w_accept = (r_state == S_IDLE) && !w_edge[3] && (|w_edge[2:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_OFF;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_OFF:   if (w_edge[3]) w_state_next = S_IDLE;
      S_IDLE:  if (w_edge[3]) w_state_next = S_OFF;
               else if (w_accept) w_state_next = S_CALC;
      S_CALC:  if (w_edge[3]) w_state_next = S_OFF;
               else if (r_cnt == 5'd0) w_state_next = S_DONE;
      S_DONE:  w_state_next = w_edge[3] ? S_OFF : S_IDLE;
      default: w_state_next = S_OFF;
    endcase
  end

  always_comb begin
    ligado = (r_state != S_OFF);
    busy   = (r_state == S_CALC);
    valid  = (r_state == S_DONE);
  end

  always_comb begin
    w_op_sel = 3'b100;
    if (w_edge[0])      w_op_sel = 3'b001;
    else if (w_edge[1]) w_op_sel = 3'b010;
  end

  logic [RW-1:0]    w_acc_next, w_addsub_mag, w_res_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_sb_eff, w_addsub_sign, w_res_sign;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_sb_eff   = r_sb ^ r_sel[2];
  assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff     = (r_a >= r_b) ? (r_a - r_b) : (r_b - r_a);

  always_comb begin
    if (r_sa == w_sb_eff) begin
      w_addsub_mag  = RW'(w_sum);
      w_addsub_sign = r_sa;
    end else begin
      w_addsub_mag  = RW'(w_diff);
      w_addsub_sign = (r_a >= r_b) ? r_sa : w_sb_eff;
    end
  end

  // zero magnitude never carries a negative sign
  assign w_res_mag  = r_sel[0] ? w_acc_next : w_addsub_mag;
  assign w_res_sign = (w_res_mag != '0) && (r_sel[0] ? (r_sa ^ r_sb) : w_addsub_sign);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_sel    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_saida  <= '0;
      r_sinal  <= 1'b0;
    end else if (w_abort) begin
      r_saida <= '0;
      r_sinal <= 1'b0;
      r_sel   <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_sa     <= sinal_a;
      r_sb     <= sinal_b;
      r_sel    <= w_op_sel;
      r_acc    <= '0;
      r_mcand  <= RW'(a);
      r_mplier <= b;
      r_cnt    <= w_op_sel[0] ? 5'(WIDTH - 1) : 5'd0;
    end else if (r_state == S_CALC) begin
      if (r_sel[0]) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (r_cnt != 5'd0) begin
        r_cnt <= r_cnt - 5'd1;
      end else begin
        r_saida <= w_res_mag;
        r_sinal <= w_res_sign;
      end
    end
  end

  assign saida       = r_saida;
  assign sinal_saida = r_sinal;
  assign sel         = r_sel;

endmodule

// File: tb/tb_seletor_sequencial.sv
// Self-checking bench for seletor_sequencial (WIDTH=8); results are predicted from signed
// integer arithmetic and checked on every valid pulse, plus hold/off rules every cycle.
module tb_seletor_sequencial;
  localparam int W    = 8;
  localparam int DBC  = 4;
  localparam int HOLD = 8;
  localparam int GAP  = 12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           sinal_a = 1'b0;
  logic           sinal_b = 1'b0;
  logic [3:0]     btn = '0;
  logic [2*W-1:0] saida;
  logic           sinal_saida;
  logic [2:0]     sel;
  logic           ligado, busy, valid;

  seletor_sequencial #(.WIDTH(W), .DEBOUNCE_CYCLES(DBC)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sinal_a(sinal_a), .sinal_b(sinal_b),
    .botao_1(btn[0]), .botao_2(btn[1]), .botao_3(btn[2]), .botao_4(btn[3]),
    .saida(saida), .sinal_saida(sinal_saida), .sel(sel),
    .ligado(ligado), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    int         mag;
    bit         sgn;
    logic [2:0] sel;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   hold_mag  = 0;
  bit   hold_sgn  = 1'b0;
  bit   prev_busy = 1'b0;
  int   busy_run  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // op: 0 mult, 1 soma, 2 subt; plain signed arithmetic on the operand values
  function automatic void model(input int op, input int av, input bit sav, input int bv,
                                input bit sbv, output exp_t e);
    int va, vb, r;
    va = sav ? -av : av;
    vb = sbv ? -bv : bv;
    case (op)
      0:       r = va * vb;
      1:       r = va + vb;
      default: r = va - vb;
    endcase
    e.mag = (r < 0) ? -r : r;
    e.sgn = (r < 0);
    e.sel = 3'(1 << op);
    e.cyc = (op == 0) ? W : 1;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("res_saida", saida, e.mag);
        check("res_sign", sinal_saida, e.sgn);
        check("res_sel", sel, e.sel);
        check("res_busy_low", busy, 1'b0);
        check("res_calc_cycles", busy_run, e.cyc);
        check("res_after_busy", prev_busy, 1'b1);
        hold_mag = e.mag;
        hold_sgn = e.sgn;
      end
    end else if (!ligado) begin
      check("off_saida", saida, 0);
      check("off_sign", sinal_saida, 0);
      check("off_sel", sel, 0);
      check("off_busy", busy, 0);
      hold_mag = 0;
      hold_sgn = 1'b0;
    end else begin
      check("hold_saida", saida, hold_mag);
      check("hold_sign", sinal_saida, hold_sgn);
    end
    if (busy) busy_run = prev_busy ? busy_run + 1 : 1;
    prev_busy = busy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_results(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_busy(input string name);
    int n = 0;
    while (!busy && n < 100) begin
      tick(1);
      n++;
    end
    check(name, busy, 1'b1);
  endtask

  task automatic press(input int idx, input int hold);
    btn[idx] = 1'b1;
    tick(hold);
    btn[idx] = 1'b0;
    tick(GAP);
  endtask

  task automatic run_op(input int op, input int av, input bit sav, input int bv, input bit sbv,
                        input int hold, input int x_mag, input bit x_sgn);
    exp_t e;
    a = W'(av);
    b = W'(bv);
    sinal_a = sav;
    sinal_b = sbv;
    model(op, av, sav, bv, sbv, e);
    exp_q.push_back(e);
    btn[op] = 1'b1;
    tick(hold);
    btn[op] = 1'b0;
    wait_results("op_done");
    check("lit_saida", saida, x_mag);
    check("lit_sign", sinal_saida, x_sgn);
    check("lit_sel", sel, e.sel);
    tick(GAP);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    tick(3);
    check("rst_saida", saida, 0);
    check("rst_sign", sinal_saida, 0);
    check("rst_sel", sel, 0);
    check("rst_ligado", ligado, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    rst_n = 1'b1;
    tick(5);

    // operation presses are ignored while off
    press(2, HOLD);
    check("off_ignore_ligado", ligado, 0);
    check("off_ignore_sel", sel, 0);

    press(3, HOLD);
    check("on_ligado", ligado, 1);
    check("on_saida", saida, 0);

    run_op(0, 5, 0, 3, 1, HOLD, 15, 1);
    run_op(1, 100, 0, 30, 1, HOLD, 70, 0);
    run_op(2, 3, 0, 10, 0, HOLD, 7, 1);
    run_op(2, 4, 0, 4, 0, HOLD, 0, 0);
    run_op(0, 255, 0, 255, 1, HOLD, 65025, 1);
    tick(5);
    check("hold_0xfe01", saida, 16'hFE01);

    run_op(0, 12, 1, 11, 1, HOLD, 132, 0);
    run_op(1, 5, 1, 7, 1, HOLD, 12, 1);
    run_op(1, 3, 0, 200, 1, HOLD, 197, 1);
    run_op(2, 9, 1, 9, 1, HOLD, 0, 0);
    run_op(0, 0, 0, 5, 1, HOLD, 0, 0);
    run_op(2, 200, 1, 100, 1, HOLD, 100, 1);
    run_op(1, 255, 0, 255, 0, HOLD, 510, 0);

    // mult and soma pressed together: mult wins
    a = 8'd7; b = 8'd6; sinal_a = 1'b0; sinal_b = 1'b0;
    model(0, 7, 0, 6, 0, e);
    exp_q.push_back(e);
    btn[0] = 1'b1; btn[1] = 1'b1;
    tick(HOLD);
    btn = '0;
    wait_results("simul_done");
    check("simul_saida", saida, 42);
    check("simul_sel", sel, 3'b001);
    tick(GAP);

    // soma pressed during a mult is dropped
    a = 8'd2; b = 8'd3;
    model(0, 2, 0, 3, 0, e);
    exp_q.push_back(e);
    btn[0] = 1'b1;
    wait_busy("calc_busy");
    btn[1] = 1'b1;
    tick(HOLD);
    btn = '0;
    wait_results("calc_done");
    tick(GAP);
    check("calc_ignore_sel", sel, 3'b001);
    check("calc_ignore_saida", saida, 6);

`ifdef SELETOR_DEBOUNCE_EN
    a = 8'd1; b = 8'd1;
    btn[1] = 1'b1;
    tick(2);
    btn[1] = 1'b0;
    tick(GAP);
    check("glitch_sel", sel, 3'b001);
    check("glitch_saida", saida, 6);
    run_op(1, 1, 0, 1, 0, 6, 2, 0);
`endif

    // on-off while idle
    press(3, HOLD);
    check("idle_off_ligado", ligado, 0);
    check("idle_off_saida", saida, 0);
    press(3, HOLD);
    check("reon_ligado", ligado, 1);
    check("reon_saida", saida, 0);

    // on-off during CALC aborts without a result
    a = 8'd9; b = 8'd9;
    btn[0] = 1'b1;
    wait_busy("abort_busy");
    btn[3] = 1'b1;
    tick(HOLD);
    btn = '0;
    tick(GAP);
    check("abort_ligado", ligado, 0);
    check("abort_saida", saida, 0);
    check("abort_sel", sel, 0);

    // reset in the 4th CALC cycle of a mult
    press(3, HOLD);
    check("pre_rst_ligado", ligado, 1);
    btn[0] = 1'b1;
    wait_busy("rst_busy");
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("midrst_saida", saida, 0);
    check("midrst_sel", sel, 0);
    check("midrst_ligado", ligado, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    btn = '0;
    tick(2);
    rst_n = 1'b1;
    tick(GAP);
    check("post_rst_ligado", ligado, 0);
    press(3, HOLD);
    check("post_rst_on", ligado, 1);

    // on-off held high across reset release must not switch on
    rst_n = 1'b0;
    btn[3] = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(GAP + 6);
    check("held_rst_ligado", ligado, 0);
    btn[3] = 1'b0;
    tick(GAP);
    check("held_release_ligado", ligado, 0);
    press(3, HOLD);
    check("held_then_on", ligado, 1);

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
